// File: rtl/serial_div_pkg.sv
// rtl/serial_div_pkg.sv - shared FSM encoding and requester count for the serial divider arbiter
package serial_div_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - two-way round-robin grant; ptr breaks ties when both requesters are valid
module rr_arbiter
    import serial_div_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               ptr,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = '0;
        if (&req) begin
            grant[ptr] = 1'b1;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/serial_div_arbiter.sv
// rtl/serial_div_arbiter.sv - shares one serial divider between two requesters (IDLE/ISSUE/WAIT/RESP)
// Optional DIV_ZERO_CHECK_EN: zero divisors bypass the divider and return all ones with resp_err.
module serial_div_arbiter
    import serial_div_pkg::*;
#(
    parameter int width = 64
)
(
    input  logic                     clk,
    input  logic                     asyn_reset,
    input  logic [2*width-1:0]       req_x,
    input  logic [2*width-1:0]       req_y,
    input  logic [NUM_REQ-1:0]       req_vld,
    output logic [NUM_REQ-1:0]       req_rdy,
    output logic [width-1:0]         resp_q,
    output logic [NUM_REQ-1:0]       resp_vld,
    input  logic [NUM_REQ-1:0]       resp_rdy,
`ifdef DIV_ZERO_CHECK_EN
    output logic                     resp_err,
`endif
    output logic [width-1:0]         div_x,
    output logic [width-1:0]         div_y,
    output logic                     div_x_vld,
    output logic                     div_y_vld,
    input  logic                     div_x_rdy,
    input  logic                     div_y_rdy,
    input  logic [width-1:0]         div_q,
    input  logic                     div_q_vld,
    output logic                     div_q_rdy,
    output logic                     busy
);

    state_e             state_q, state_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic               owner_q, owner_d;
    logic [width-1:0]   opx_q, opx_d;
    logic [width-1:0]   opy_q, opy_d;
    logic [width-1:0]   res_q, res_d;
    logic               x_done_q, x_done_d;
    logic               y_done_q, y_done_d;
`ifdef DIV_ZERO_CHECK_EN
    logic               err_q, err_d;
`endif

    logic [NUM_REQ-1:0] grant;
    logic               gsel;
    logic [width-1:0]   sel_x;
    logic [width-1:0]   sel_y;

    rr_arbiter u_rr_arbiter (
        .req   (req_vld),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    assign gsel  = grant[1];
    assign sel_x = gsel ? req_x[2*width-1:width] : req_x[width-1:0];
    assign sel_y = gsel ? req_y[2*width-1:width] : req_y[width-1:0];

    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= 1'b0;
            owner_q  <= 1'b0;
            opx_q    <= '0;
            opy_q    <= '0;
            res_q    <= '0;
            x_done_q <= 1'b0;
            y_done_q <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            opx_q    <= opx_d;
            opy_q    <= opy_d;
            res_q    <= res_d;
            x_done_q <= x_done_d;
            y_done_q <= y_done_d;
`ifdef DIV_ZERO_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        opx_d    = opx_q;
        opy_d    = opy_q;
        res_d    = res_q;
        x_done_d = x_done_q;
        y_done_d = y_done_q;
`ifdef DIV_ZERO_CHECK_EN
        err_d    = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    owner_d  = gsel;
                    rr_ptr_d = ~gsel;
                    opx_d    = sel_x;
                    opy_d    = sel_y;
                    x_done_d = 1'b0;
                    y_done_d = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
                    if (sel_y == '0) begin
                        state_d = ST_RESP;
                        res_d   = '1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                        err_d   = 1'b0;
                    end
`else
                    state_d = ST_ISSUE;
`endif
                end
            end
            ST_ISSUE: begin
                // Each operand channel completes on its own; leave only when both have.
                x_done_d = x_done_q | (div_x_vld & div_x_rdy);
                y_done_d = y_done_q | (div_y_vld & div_y_rdy);
                if (x_done_d && y_done_d) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (div_q_vld) begin
                    res_d   = div_q;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_rdy[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_rdy   = '0;
        resp_vld  = '0;
        div_x_vld = 1'b0;
        div_y_vld = 1'b0;
        div_q_rdy = 1'b0;
        case (state_q)
            ST_IDLE:  req_rdy = grant & ~{NUM_REQ{asyn_reset}};
            ST_ISSUE: begin
                div_x_vld = ~x_done_q;
                div_y_vld = ~y_done_q;
            end
            ST_WAIT:  div_q_rdy = 1'b1;
            ST_RESP:  resp_vld[owner_q] = 1'b1;
            default:  req_rdy = '0;
        endcase
    end

    assign busy   = (state_q != ST_IDLE);
    assign resp_q = res_q;
    assign div_x  = opx_q;
    assign div_y  = opy_q;
`ifdef DIV_ZERO_CHECK_EN
    assign resp_err = err_q & (state_q == ST_RESP);
`endif

endmodule

// File: tb/tb_serial_div_arbiter.sv
// tb/tb_serial_div_arbiter.sv - scoreboard bench for serial_div_arbiter with a behavioural divider
module tb_serial_div_arbiter;

    localparam int W = 32;

    typedef struct packed {
        logic         err;
        logic         owner;
        logic [W-1:0] q;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
    } job_t;

    logic           clk;
    logic           asyn_reset;
    logic [2*W-1:0] req_x;
    logic [2*W-1:0] req_y;
    logic [1:0]     req_vld;
    logic [1:0]     req_rdy;
    logic [W-1:0]   resp_q;
    logic [1:0]     resp_vld;
    logic [1:0]     resp_rdy;
`ifdef DIV_ZERO_CHECK_EN
    logic           resp_err;
`endif
    logic [W-1:0]   div_x;
    logic [W-1:0]   div_y;
    logic           div_x_vld;
    logic           div_y_vld;
    logic           div_x_rdy;
    logic           div_y_rdy;
    logic [W-1:0]   div_q;
    logic           div_q_vld;
    logic           div_q_rdy;
    logic           busy;

    serial_div_arbiter #(.width(W)) dut (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_vld    (req_vld),
        .req_rdy    (req_rdy),
        .resp_q     (resp_q),
        .resp_vld   (resp_vld),
        .resp_rdy   (resp_rdy),
`ifdef DIV_ZERO_CHECK_EN
        .resp_err   (resp_err),
`endif
        .div_x      (div_x),
        .div_y      (div_y),
        .div_x_vld  (div_x_vld),
        .div_y_vld  (div_y_vld),
        .div_x_rdy  (div_x_rdy),
        .div_y_rdy  (div_y_rdy),
        .div_q      (div_q),
        .div_q_vld  (div_q_vld),
        .div_q_rdy  (div_q_rdy),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    job_t rq0[$];
    job_t rq1[$];
    exp_t sb[$];
    int   n_pass;
    int   n_chk;

    logic [W-1:0] m_x, m_y, m_q;
    bit           m_have_x, m_have_y, m_busy;
    int           m_cnt, m_y_wait, div_lat, y_rdy_delay, n_div_hs;
    logic [1:0]   sink_rdy;

    logic [1:0]   s_req_rdy, s_resp_vld, hs_req, hs_resp;
    logic [W-1:0] s_resp_q, s_div_x, s_div_y;
    logic         s_busy, s_div_x_vld, s_div_y_vld, s_div_q_rdy, s_err, s_rst;
    logic         hs_x, hs_y, hs_q;
    int           cyc, t_acc, t_resp_hs, last_lat, last_gap, n_rdy0;
    bit           lat_armed;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic push_job(input int who, input int x, input int y, input logic [W-1:0] q, input logic err);
        job_t j;
        exp_t e;
        j.x = W'(x);
        j.y = W'(y);
        e.err = err;
        e.owner = (who == 1);
        e.q = q;
        if (who == 0) rq0.push_back(j);
        else rq1.push_back(j);
        sb.push_back(e);
    endtask

    // One clock: drive at negedge, sample 1ns later, then apply handshakes seen at the posedge.
    task automatic step();
        exp_t e;
        req_vld[0] = (rq0.size() != 0);
        req_vld[1] = (rq1.size() != 0);
        if (rq0.size() != 0) begin
            req_x[W-1:0] = rq0[0].x;
            req_y[W-1:0] = rq0[0].y;
        end
        if (rq1.size() != 0) begin
            req_x[2*W-1:W] = rq1[0].x;
            req_y[2*W-1:W] = rq1[0].y;
        end
        div_x_rdy = !m_have_x && !m_busy;
        div_y_rdy = !m_have_y && !m_busy && (y_rdy_delay == 0 || (m_have_x && m_y_wait == 0));
        div_q_vld = m_busy && (m_cnt == 0);
        div_q     = m_q;
        resp_rdy  = sink_rdy;
        #1;
        s_req_rdy   = req_rdy;
        s_resp_vld  = resp_vld;
        s_resp_q    = resp_q;
        s_busy      = busy;
        s_div_x_vld = div_x_vld;
        s_div_y_vld = div_y_vld;
        s_div_q_rdy = div_q_rdy;
        s_div_x     = div_x;
        s_div_y     = div_y;
`ifdef DIV_ZERO_CHECK_EN
        s_err       = resp_err;
`else
        s_err       = 1'b0;
`endif
        s_rst   = asyn_reset;
        hs_req  = req_vld & req_rdy;
        hs_resp = resp_vld & resp_rdy;
        hs_x    = div_x_vld & div_x_rdy;
        hs_y    = div_y_vld & div_y_rdy;
        hs_q    = div_q_vld & div_q_rdy;
        @(negedge clk);
        cyc++;
        if (s_req_rdy[0]) n_rdy0++;
        if (hs_req[0]) void'(rq0.pop_front());
        if (hs_req[1]) void'(rq1.pop_front());
        if (|hs_req) begin
            last_gap  = cyc - t_resp_hs;
            t_acc     = cyc;
            lat_armed = 1'b1;
        end
        if (lat_armed && |s_resp_vld) begin
            last_lat  = cyc - t_acc;
            lat_armed = 1'b0;
        end
        if (|hs_resp) begin
            t_resp_hs = cyc;
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("resp_owner", hs_resp, e.owner ? 2'b10 : 2'b01);
                chk("resp_q", s_resp_q, e.q);
`ifdef DIV_ZERO_CHECK_EN
                chk("resp_err", s_err, e.err);
`endif
            end
        end
        if (s_rst) begin
            m_have_x = 1'b0;
            m_have_y = 1'b0;
            m_busy   = 1'b0;
            m_cnt    = 0;
            m_y_wait = 0;
        end else begin
            if (hs_x) begin
                m_x = s_div_x;
                m_have_x = 1'b1;
                m_y_wait = y_rdy_delay;
                n_div_hs++;
            end else if (m_have_x && m_y_wait > 0) begin
                m_y_wait--;
            end
            if (hs_y) begin
                m_y = s_div_y;
                m_have_y = 1'b1;
                n_div_hs++;
            end
            if (hs_q) m_busy = 1'b0;
            else if (m_busy && m_cnt > 0) m_cnt--;
            if (m_have_x && m_have_y) begin
                m_q = (m_y == 0) ? '1 : m_x / m_y;
                m_busy = 1'b1;
                m_cnt = div_lat;
                m_have_x = 1'b0;
                m_have_y = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        asyn_reset = 1'b1;
        step();
        step();
        asyn_reset = 1'b0;
    endtask

    task automatic run_until_done(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((rq0.size() != 0 || rq1.size() != 0 || sb.size() != 0 || s_busy) && n < 1000);
        if (n >= 1000) chk({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int n, n0;
        n_pass = 0; n_chk = 0;
        asyn_reset = 1'b1;
        req_x = '0; req_y = '0; req_vld = '0; resp_rdy = '0;
        div_x_rdy = 1'b0; div_y_rdy = 1'b0; div_q = '0; div_q_vld = 1'b0;
        m_x = '0; m_y = '0; m_q = '0; m_have_x = 0; m_have_y = 0; m_busy = 0;
        m_cnt = 0; m_y_wait = 0; div_lat = 0; y_rdy_delay = 0; n_div_hs = 0;
        sink_rdy = 2'b11;
        cyc = 0; t_acc = 0; t_resp_hs = 0; last_lat = -1; last_gap = -1; n_rdy0 = 0; lat_armed = 0;
        @(negedge clk);

        do_reset();
        step();
        chk("rst_busy", s_busy, 0);
        chk("rst_req_rdy", s_req_rdy, 0);
        chk("rst_resp_vld", s_resp_vld, 0);
        chk("rst_div_vld", {s_div_x_vld, s_div_y_vld, s_div_q_rdy}, 0);
        chk("rst_resp_q", s_resp_q, 0);

        // Single requester, 100/7.
        n_rdy0 = 0;
        push_job(0, 100, 7, 14, 1'b0);
        run_until_done("t1");
        chk("t1_rdy0_pulses", n_rdy0, 1);
        chk("t1_div_x", m_x, 100);
        chk("t1_div_y", m_y, 7);
        chk("t1_latency", last_lat, 3);
        step();
        chk("t1_busy_after", s_busy, 0);

        // Simultaneous requests right after reset: requester 0 wins.
        do_reset();
        push_job(0, 50, 5, 10, 1'b0);
        push_job(1, 81, 9, 9, 1'b0);
        run_until_done("t2");
        chk("t2_idle_gap", last_gap, 1);
        chk("t2_latency", last_lat, 3);

        // Requester 0 continuously valid beside requester 1; grants alternate.
        div_lat = 3;
        push_job(0, 20, 4, 5, 1'b0);
        push_job(1, 30, 3, 10, 1'b0);
        push_job(0, 1000, 10, 100, 1'b0);
        push_job(1, 7, 8, 0, 1'b0);
        run_until_done("t3");
        chk("t3_latency", last_lat, 6);
        div_lat = 0;

        // div_y_rdy held off 5 cycles behind div_x_rdy.
        y_rdy_delay = 5;
        push_job(0, 77, 7, 11, 1'b0);
        n = 0;
        do begin step(); n++; end while (!hs_x && n < 50);
        if (!hs_x) chk("t4_x_hs_timeout", 0, 1);
        n = 0;
        do begin
            step();
            n++;
            if (!hs_y) begin
                chk("t4_x_vld_low", s_div_x_vld, 0);
                chk("t4_y_vld_high", s_div_y_vld, 1);
                chk("t4_not_wait", s_div_q_rdy, 0);
            end
        end while (!hs_y && n < 50);
        chk("t4_y_hs_cycle", n, 6);
        step();
        chk("t4_wait_entered", s_div_q_rdy, 1);
        y_rdy_delay = 0;
        run_until_done("t4");

        // Owner stalls resp_rdy for 10 cycles; non-owner's resp_rdy is high and ignored.
        sink_rdy = 2'b10;
        push_job(0, 90, 9, 10, 1'b0);
        n = 0;
        do begin step(); n++; end while (s_resp_vld == 0 && n < 50);
        if (s_resp_vld == 0) chk("t5_resp_timeout", 0, 1);
        push_job(1, 64, 8, 8, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t5_hold_vld", s_resp_vld, 2'b01);
            chk("t5_hold_q", s_resp_q, 10);
            chk("t5_no_accept1", s_req_rdy[1], 0);
        end
        sink_rdy = 2'b11;
        run_until_done("t5");

        // Reset while waiting on the divider abandons the job and clears rr_ptr.
        div_lat = 20;
        rq0.push_back(job_t'{W'(55), W'(5)});
        n = 0;
        do begin step(); n++; end while (!s_div_q_rdy && n < 50);
        if (!s_div_q_rdy) chk("t6_wait_timeout", 0, 1);
        asyn_reset = 1'b1;
        step();
        asyn_reset = 1'b0;
        step();
        chk("t6_busy", s_busy, 0);
        chk("t6_req_rdy", s_req_rdy, 0);
        chk("t6_resp_vld", s_resp_vld, 0);
        chk("t6_div_vld", {s_div_x_vld, s_div_y_vld, s_div_q_rdy}, 0);
        chk("t6_resp_q", s_resp_q, 0);
        chk("t6_div_x", s_div_x, 0);
        chk("t6_div_y", s_div_y, 0);
        div_lat = 0;
        push_job(0, 12, 4, 3, 1'b0);
        push_job(1, 40, 8, 5, 1'b0);
        run_until_done("t6");

`ifdef DIV_ZERO_CHECK_EN
        n0 = n_div_hs;
        push_job(0, 5, 0, {W{1'b1}}, 1'b1);
        run_until_done("t7");
        chk("t7_no_div_hs", n_div_hs, n0);
        push_job(1, 9, 3, 3, 1'b0);
        run_until_done("t7b");
`else
        n0 = 0;
`endif
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
